// File: rtl/analyzer_result_sequencer.sv
// Sequences one analyzer measurement run: clear, measure, settle, snapshot,
// then publishes the result words to the AXI register bank and pulses irq.
module analyzer_result_sequencer #(
    parameter int unsigned NUMBER_OF_REGISTERS = 6,
    parameter int unsigned REGISTER_BASE       = 1,
    parameter int unsigned WRITE_OPERATION     = 2,
    parameter int unsigned CLEAR_CYCLES        = 2,
    parameter int unsigned SETTLE_CYCLES       = 4,
    parameter int unsigned MEASURE_CYCLES      = 0
) (
    input  logic                                s00_axi_aclk,
    input  logic                                s00_axi_aresetn,
    input  logic                                start,
    input  logic                                stop,
    input  logic [32*NUMBER_OF_REGISTERS-1:0]   results,
    output logic                                analyzer_enable,
    output logic                                analyzer_clear_n,
    output logic [1:0]                          register_operation,
    output logic [7:0]                          register_number,
    output logic [31:0]                         register_write,
    output logic                                busy,
    output logic                                window_expired,
    output logic                                irq
);

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned RESULTS_W = WORD_W * NUMBER_OF_REGISTERS;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned PHASE_W   = 8;
    localparam int unsigned WINDOW_W  = 32;

    localparam logic [IDX_W-1:0]    LAST_INDEX     = IDX_W'(NUMBER_OF_REGISTERS - 1);
    localparam logic [PHASE_W-1:0]  CLEAR_LAST     = PHASE_W'(CLEAR_CYCLES - 1);
    localparam logic [PHASE_W-1:0]  SETTLE_LAST    = PHASE_W'(SETTLE_CYCLES - 1);
    localparam bit                  WINDOW_BOUNDED = (MEASURE_CYCLES != 0);
    localparam logic [WINDOW_W-1:0] WINDOW_LAST    = WINDOW_W'(MEASURE_CYCLES - 1);
    localparam logic [1:0]          WRITE_OP       = 2'(WRITE_OPERATION);
    localparam logic [7:0]          BASE_NUMBER    = 8'(REGISTER_BASE);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        MEASURE,
        SETTLE,
        WRITE,
        DONE
    } state_t;

    state_t                 state;
    logic [PHASE_W-1:0]     phase_cnt;
    logic [WINDOW_W-1:0]    window_cnt;
    logic [IDX_W-1:0]       wr_idx;
    logic [IDX_W-1:0]       next_idx;
    logic [RESULTS_W-1:0]   snapshot;

    assign next_idx = wr_idx + IDX_W'(1);

    function automatic logic [WORD_W-1:0] word_at(input logic [RESULTS_W-1:0] words,
                                                  input logic [IDX_W-1:0]     idx);
        return words[WORD_W*idx +: WORD_W];
    endfunction

    // Single sequencing process; every output is a register.
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            state              <= IDLE;
            phase_cnt          <= '0;
            window_cnt         <= '0;
            wr_idx             <= '0;
            snapshot           <= '0;
            analyzer_enable    <= 1'b0;
            analyzer_clear_n   <= 1'b1;
            register_operation <= '0;
            register_number    <= '0;
            register_write     <= '0;
            busy               <= 1'b0;
            window_expired     <= 1'b0;
            irq                <= 1'b0;
        end else begin
            irq <= 1'b0;
            unique case (state)
                IDLE: begin
                    // stop overrides a simultaneous start
                    if (start && !stop) begin
                        state            <= CLEAR;
                        busy             <= 1'b1;
                        analyzer_clear_n <= 1'b0;
                        phase_cnt        <= '0;
                        window_expired   <= 1'b0;
                    end
                end

                CLEAR: begin
                    if (stop) begin
                        state            <= IDLE;
                        analyzer_clear_n <= 1'b1;
                        busy             <= 1'b0;
                    end else if (phase_cnt == CLEAR_LAST) begin
                        state            <= MEASURE;
                        analyzer_clear_n <= 1'b1;
                        analyzer_enable  <= 1'b1;
                        window_cnt       <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + PHASE_W'(1);
                    end
                end

                MEASURE: begin
                    if (stop) begin
                        state           <= SETTLE;
                        analyzer_enable <= 1'b0;
                        phase_cnt       <= '0;
                    end else if (WINDOW_BOUNDED && (window_cnt == WINDOW_LAST)) begin
                        state           <= SETTLE;
                        analyzer_enable <= 1'b0;
                        phase_cnt       <= '0;
                        window_expired  <= 1'b1;
                    end else if (window_cnt != '1) begin
                        window_cnt <= window_cnt + WINDOW_W'(1);
                    end
                end

                SETTLE: begin
                    // Last settle cycle: capture results and present word 0 at once
                    if (phase_cnt == SETTLE_LAST) begin
                        state              <= WRITE;
                        snapshot           <= results;
                        wr_idx             <= '0;
                        register_operation <= WRITE_OP;
                        register_number    <= BASE_NUMBER;
                        register_write     <= results[WORD_W-1:0];
                    end else begin
                        phase_cnt <= phase_cnt + PHASE_W'(1);
                    end
                end

                WRITE: begin
                    if (wr_idx == LAST_INDEX) begin
                        state              <= DONE;
                        register_operation <= '0;
                        register_number    <= '0;
                        register_write     <= '0;
                        irq                <= 1'b1;
                    end else begin
                        wr_idx          <= next_idx;
                        register_number <= BASE_NUMBER + 8'(next_idx);
                        register_write  <= word_at(snapshot, next_idx);
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_analyzer_result_sequencer.sv
// Randomized scoreboard bench for analyzer_result_sequencer: a run-level timing
// model predicts spans, write beats and irq; a monitor checks them as they appear.
module tb_analyzer_result_sequencer;

    localparam int N    = 6;
    localparam int BASE = 1;
    localparam int WOP  = 2;
    localparam int CLR  = 2;
    localparam int SET  = 4;
    localparam int MEAS = 20;

    logic              pixel_clock = 1'b0;
    logic              rst_n;
    logic              start;
    logic              stop;
    logic [32*N-1:0]   results;
    logic              analyzer_enable;
    logic              analyzer_clear_n;
    logic [1:0]        register_operation;
    logic [7:0]        register_number;
    logic [31:0]       register_write;
    logic              busy;
    logic              window_expired;
    logic              irq;

    analyzer_result_sequencer #(
        .NUMBER_OF_REGISTERS (N),
        .REGISTER_BASE       (BASE),
        .WRITE_OPERATION     (WOP),
        .CLEAR_CYCLES        (CLR),
        .SETTLE_CYCLES       (SET),
        .MEASURE_CYCLES      (MEAS)
    ) dut (
        .s00_axi_aclk       (pixel_clock),
        .s00_axi_aresetn    (rst_n),
        .start              (start),
        .stop               (stop),
        .results            (results),
        .analyzer_enable    (analyzer_enable),
        .analyzer_clear_n   (analyzer_clear_n),
        .register_operation (register_operation),
        .register_number    (register_number),
        .register_write     (register_write),
        .busy               (busy),
        .window_expired     (window_expired),
        .irq                (irq)
    );

    always #5 pixel_clock = ~pixel_clock;

    // Edge count: after rising edge k the value is k.
    int cyc = 0;
    always @(posedge pixel_clock) cyc <= cyc + 1;

    int n_compared   = 0;
    int n_mismatched = 0;
    bit mon_en       = 1'b0;

    typedef struct {
        int          cyc;
        logic [7:0]  num;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int first;
        int len;
    } span_t;

    typedef struct {
        int cyc;
        bit expired;
    } irq_t;

    wr_t   exp_wr[$];
    span_t exp_clr[$];
    span_t exp_en[$];
    span_t exp_busy[$];
    irq_t  exp_irq[$];

    task automatic check(input string name, input longint act, input longint exp);
        n_compared++;
        if (act != exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_compared++;
        n_mismatched++;
        $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_enable"},    analyzer_enable,    0);
        check({tag, "_clear_n"},   analyzer_clear_n,   1);
        check({tag, "_operation"}, register_operation, 0);
        check({tag, "_number"},    register_number,    0);
        check({tag, "_write"},     register_write,     0);
        check({tag, "_busy"},      busy,               0);
        check({tag, "_expired"},   window_expired,     0);
        check({tag, "_irq"},       irq,                0);
    endtask

    task automatic randomize_results();
        for (int i = 0; i < N; i++) results[32*i +: 32] = $urandom;
    endtask

    task automatic step(input bit scramble);
        @(negedge pixel_clock);
        if (scramble) randomize_results();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    // One run from IDLE. d: stop d cycles after enable rises (0 or >MEAS = let window expire).
    // abort_beat: if nonzero, reset is held during that write beat.
    task automatic run(input int d, input bit scramble, input bit hold, input int abort_beat);
        int t, e, s, w0, irq_c, fall, beats;
        bit expx;
        t = cyc + 1;
        e = t + CLR;
        if (d >= 1 && d <= MEAS) begin
            s = e + d;
            expx = 1'b0;
        end else begin
            s = e + MEAS;
            expx = 1'b1;
        end
        w0    = s + SET;
        irq_c = w0 + N;
        beats = (abort_beat != 0) ? abort_beat : N;
        fall  = (abort_beat != 0) ? w0 + abort_beat : irq_c + 1;
        exp_clr.push_back('{t, CLR});
        exp_en.push_back('{e, s - e});
        exp_busy.push_back('{t, fall - t});
        if (abort_beat == 0) exp_irq.push_back('{irq_c, expx});

        start = 1'b1;
        step(scramble);
        if (!hold) start = 1'b0;
        while (cyc < s - 1) step(scramble);
        stop = !expx;
        step(scramble);
        stop = 1'b0;
        while (cyc < w0 - 1) step(scramble);
        // results now hold the value captured on the last settle cycle
        for (int i = 0; i < beats; i++)
            exp_wr.push_back('{w0 + i, 8'(BASE + i), results[32*i +: 32]});
        if (abort_beat != 0) begin
            while (cyc < fall - 1) step(scramble);
            rst_n = 1'b0;
            step(scramble);
            check_reset_values("abort");
            rst_n = 1'b1;
        end else begin
            while (cyc < irq_c + 1) step(scramble);
        end
    endtask

    // Monitor: pops expectations whenever the DUT shows the matching event.
    initial begin : monitor
        bit    pc, pe, pb;
        int    clr_t, en_t, busy_t;
        wr_t   w;
        span_t sp;
        irq_t  ir;
        clr_t = 0; en_t = 0; busy_t = 0;
        wait (mon_en);
        pc = analyzer_clear_n;
        pe = analyzer_enable;
        pb = busy;
        forever begin
            @(negedge pixel_clock);
            if (register_operation != 2'd0) begin
                if (exp_wr.size() == 0) unexpected("write");
                else begin
                    w = exp_wr.pop_front();
                    check("write_op",     register_operation, WOP);
                    check("write_cycle",  cyc,                w.cyc);
                    check("write_number", register_number,    w.num);
                    check("write_data",   register_write,     w.data);
                end
            end else begin
                check("idle_number", register_number, 0);
                check("idle_data",   register_write,  0);
            end
            if (irq) begin
                if (exp_irq.size() == 0) unexpected("irq");
                else begin
                    ir = exp_irq.pop_front();
                    check("irq_cycle",      cyc,            ir.cyc);
                    check("window_expired", window_expired, ir.expired);
                end
            end
            if (!analyzer_clear_n && pc) clr_t = cyc;
            if (analyzer_clear_n && !pc) begin
                if (exp_clr.size() == 0) unexpected("clear");
                else begin
                    sp = exp_clr.pop_front();
                    check("clear_start", clr_t,       sp.first);
                    check("clear_len",   cyc - clr_t, sp.len);
                end
            end
            if (analyzer_enable && !pe) en_t = cyc;
            if (!analyzer_enable && pe) begin
                if (exp_en.size() == 0) unexpected("enable");
                else begin
                    sp = exp_en.pop_front();
                    check("enable_start", en_t,       sp.first);
                    check("enable_len",   cyc - en_t, sp.len);
                end
            end
            if (busy && !pb) busy_t = cyc;
            if (!busy && pb) begin
                if (exp_busy.size() == 0) unexpected("busy");
                else begin
                    sp = exp_busy.pop_front();
                    check("busy_start", busy_t,       sp.first);
                    check("busy_len",   cyc - busy_t, sp.len);
                end
            end
            pc = analyzer_clear_n;
            pe = analyzer_enable;
            pb = busy;
        end
    end

    initial begin : driver
        rst_n   = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        results = '0;
        repeat (3) @(negedge pixel_clock);
        check_reset_values("reset");
        rst_n  = 1'b1;
        mon_en = 1'b1;
        idle(1);

        // Fixed 0x11..0x66, stop 10 cycles after enable
        for (int i = 0; i < N; i++) results[32*i +: 32] = 32'h11 * (i + 1);
        run(10, 1'b0, 1'b0, 0);
        idle(3);

        // Window expiry, then stop coinciding with expiry
        randomize_results();
        run(0, 1'b0, 1'b0, 0);
        idle(2);
        run(MEAS, 1'b1, 1'b0, 0);

        // start and stop together in IDLE: nothing happens
        start = 1'b1;
        stop  = 1'b1;
        step(1'b0);
        start = 1'b0;
        stop  = 1'b0;
        idle(4);

        // stop during CLEAR: one clear cycle, then back to IDLE
        exp_clr.push_back('{cyc + 1, 1});
        exp_busy.push_back('{cyc + 1, 1});
        start = 1'b1;
        step(1'b0);
        start = 1'b0;
        stop  = 1'b1;
        step(1'b0);
        stop  = 1'b0;
        idle(3);

        // results changing every cycle, including during WRITE
        run(5, 1'b1, 1'b0, 0);

        // reset on the third write beat, then a clean run
        run(10, 1'b1, 1'b0, 3);
        idle(1);
        run(10, 1'b0, 1'b0, 0);

        // start held high: back-to-back runs
        run(0, 1'b0, 1'b1, 0);
        run(0, 1'b1, 1'b1, 0);
        run(0, 1'b0, 1'b1, 0);
        start = 1'b0;
        idle(3);

        // Random runs
        for (int k = 0; k < 8; k++) begin
            idle(int'($urandom_range(0, 3)));
            run(int'($urandom_range(0, 30)), 1'($urandom_range(0, 1)), 1'b0, 0);
        end
        idle(5);

        check("pending_writes", exp_wr.size(),   0);
        check("pending_irq",    exp_irq.size(),  0);
        check("pending_clear",  exp_clr.size(),  0);
        check("pending_enable", exp_en.size(),   0);
        check("pending_busy",   exp_busy.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/analyzer_result_sequencer.md
# analyzer_result_sequencer

Controls one measurement run of the three pixel frequency analyzers and publishes their six action-time results to the AXI register bank. The block does the following in order:
- clears the analyzers and enables them for a measurement window;
- lets their outputs settle, then snapshots all six 32-bit results;
- writes the results one per cycle through the `register_operation` / `register_number` / `register_write` port of `axi_slave_impl`;
- pulses `irq`.

It sits between the start/stop control inputs, the `frequency_analyzer` instances and the AXI slave register interface. It replaces ad-hoc write logic with a deterministic sequence.

## Interface
Parameters:
- `NUMBER_OF_REGISTERS`, 6: result words written per run (1..8).
- `REGISTER_BASE`, 1: `register_number` of the first result word.
- `WRITE_OPERATION`, 2: `register_operation` code for a write.
- `CLEAR_CYCLES`, 2: cycles `analyzer_clear_n` is held low (1..255).
- `SETTLE_CYCLES`, 4: cycles between enable deassert and snapshot (1..255).
- `MEASURE_CYCLES`, 0: measurement window length in clocks. 0 means the window is unbounded and only `stop` ends it.

Ports:
- `s00_axi_aclk`, in, 1: the single clock.
- `s00_axi_aresetn`, in, 1: reset. Synchronous, active-low.
- `start`, in, 1: request a run. Sampled on each rising edge; must be synchronous to `s00_axi_aclk`.
- `stop`, in, 1: end measurement early. Sampled on each rising edge.
- `results`, in, 32*`NUMBER_OF_REGISTERS`: analyzer outputs. Word i occupies bits [32i+31:32i].
- `analyzer_enable`, out, 1: enable to all analyzers.
- `analyzer_clear_n`, out, 1: active-low clear to all analyzers.
- `register_operation`, out, 2: 0 = idle, `WRITE_OPERATION` = write.
- `register_number`, out, 8: target register.
- `register_write`, out, 32: write data.
- `busy`, out, 1: high in every state except IDLE.
- `window_expired`, out, 1: high when the last run ended by window expiry rather than by `stop`.
- `irq`, out, 1: one-cycle completion pulse.

## Operation
- All outputs are registered.
- Reset values: `analyzer_enable`=0, `analyzer_clear_n`=1, `register_operation`=0, `register_number`=0, `register_write`=0, `busy`=0, `window_expired`=0, `irq`=0, state IDLE.
- Reset asserted in any state returns everything to the reset values at the next edge. No partial write sequence completes.
- States: IDLE, CLEAR, MEASURE, SETTLE, WRITE, DONE.
- IDLE:
  - `start`=1 and `stop`=0 → CLEAR; `window_expired` is cleared.
  - `start` and `stop` both high → stop wins; the block stays in IDLE.
- CLEAR: `analyzer_clear_n`=0 for exactly `CLEAR_CYCLES` cycles, then → MEASURE.
  - `stop` during CLEAR → IDLE, with `analyzer_clear_n` released and no writes or `irq`.
- MEASURE: `analyzer_enable`=1. A 32-bit window counter starts at 0 and increments each cycle.
  - `stop` → SETTLE; `window_expired` stays 0.
  - Otherwise, when `MEASURE_CYCLES`≠0 and the counter equals `MEASURE_CYCLES`-1 → SETTLE with `window_expired`=1.
  - `stop` arriving in the same cycle as expiry → treated as `stop` (`window_expired`=0).
  - `start` is ignored.
- SETTLE: `analyzer_enable`=0 for `SETTLE_CYCLES` cycles. On the last SETTLE cycle all of `results` is copied into an internal snapshot. State then → WRITE with index 0.
- WRITE: one word per cycle, for index i = 0..`NUMBER_OF_REGISTERS`-1:
  - `register_operation`=`WRITE_OPERATION`
  - `register_number`=`REGISTER_BASE`+i
  - `register_write`=snapshot word i
  - After the last index → DONE.
  - `start` and `stop` are ignored.
  - The written data comes from the snapshot, so changes on `results` during WRITE are never visible.
- DONE: `register_operation`, `register_number` and `register_write` return to 0; `irq`=1 for one cycle; → IDLE.
- `start` held high continuously begins a new run on the first IDLE cycle after DONE.
- Width rules:
  - `register_number` is 8 bits, computed as `REGISTER_BASE`+i truncated to 8 bits.
  - The window counter saturates and never wraps; only the compare matters.

## Timing
- `start` sampled at edge T:
  - `busy` and `analyzer_clear_n`=0 from T+1.
  - `analyzer_clear_n` returns to 1 and `analyzer_enable`=1 at T+1+`CLEAR_CYCLES`.
- `stop` sampled at edge S in MEASURE:
  - `analyzer_enable`=0 at S+1.
  - First write visible at S+1+`SETTLE_CYCLES`.
  - Last write visible at S+`SETTLE_CYCLES`+`NUMBER_OF_REGISTERS`.
  - `irq` at S+1+`SETTLE_CYCLES`+`NUMBER_OF_REGISTERS`.
  - `busy` low one cycle after `irq`.
- Window expiry with `MEASURE_CYCLES`=M: `analyzer_enable` is high for exactly M cycles.
- Write beats are back-to-back, with no gaps and no handshake; `axi_slave_impl` accepts one write per clock.

## Test plan
- Reset, then `start` pulse; `stop` 10 cycles after enable rises; `results` = 0x11..0x66. Required: 6 consecutive writes, `register_number` 1..6, data 0x11..0x66; `irq` exactly once; `window_expired`=0.
- `MEASURE_CYCLES`=20, no `stop`. Required: `analyzer_enable` high exactly 20 cycles; `window_expired`=1; 6 writes.
- `results` changes on every cycle of WRITE. Required: written data equals the value sampled on the last SETTLE cycle.
- `start`+`stop` together in IDLE, and `stop` during CLEAR. Required: no enable or an aborted run, no writes, no `irq`, return to IDLE.
- `s00_axi_aresetn` low on the third write beat. Required: all outputs at reset values next edge; no `irq`; a following `start` produces a full clean run.
- `start` held high. Required: back-to-back runs, each with a CLEAR phase and 6 writes; `start` ignored during MEASURE/WRITE.
